imem_resp_unit: RTL

- Responder side of the instruction-fetch interface.
- Accepts PC fetch requests from the fetch stage and issues them to a fixed-latency instruction SRAM.
- Tracks in-flight reads and buffers returned instructions in a small FIFO so decode can stall without losing data.
- Credit-based backpressure to fetch; flush on redirect discards all in-flight and buffered responses.

---
 rtl/core_types_pkg.sv | 16 +
 rtl/dl_fifo_sync.sv | 90 +++++++++
 rtl/dl_fifo_sync_chk.sv | 13 +
 rtl/imem_resp_unit_chk.sv | 19 +
 rtl/imem_resp_unit.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: address width, instruction-memory response record and limits.
// The err field of imem_resp_t exists only when IMEM_MISALIGN_CHK_EN is defined.
package core_types_pkg;

  localparam int N_BITS       = 32;
  localparam int IMEM_LAT_MAX = 4;

  typedef struct packed {
    logic [N_BITS-1:0] pc;
    logic [31:0]       instr;
`ifdef IMEM_MISALIGN_CHK_EN
    logic              err;
`endif
  } imem_resp_t;

endpackage

// File: rtl/dl_fifo_sync.sv
// Synchronous FIFO with register storage, head read straight from storage (no bypass).
// Pointers wrap modulo DEPTH (power of 2); clr empties it in one cycle.
module dl_fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == CW'(0));
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A pop on empty is ignored; a push on full only succeeds alongside a real pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  dl_fifo_sync_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .full  (full)
  );

endmodule

// File: rtl/dl_fifo_sync_chk.sv
// Assertion checker for dl_fifo_sync: a push must never land on a full FIFO
// unless a pop frees the slot in the same cycle.
module dl_fifo_sync_chk (
  input logic clk,
  input logic rst_n,
  input logic push,
  input logic pop,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/imem_resp_unit_chk.sv
// Assertion checker for imem_resp_unit credit accounting.
module imem_resp_unit_chk #(
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  input logic [$clog2(DEPTH):0]  outstanding,
  input logic [$clog2(DEPTH):0]  fifo_count,
  input logic                    fifo_full
);

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
                                   outstanding <= ($clog2(DEPTH)+1)'(DEPTH));
  a_fifo_covered: assert property (@(posedge clk) disable iff (!rst_n)
                                   fifo_count <= outstanding);
  a_full_credit:  assert property (@(posedge clk) disable iff (!rst_n)
                                   fifo_full |-> (outstanding == ($clog2(DEPTH)+1)'(DEPTH)));

endmodule

// File: rtl/imem_resp_unit.sv
// Instruction-fetch responder: issues PCs to a fixed-latency SRAM, buffers returns in a FIFO.
// Optional IMEM_MISALIGN_CHK_EN flags misaligned PCs as error responses without an SRAM read.
module imem_resp_unit
  import core_types_pkg::*;
#(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [N_BITS-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_BITS-1:0] resp_pc,
  output logic [31:0]       resp_instr,
  output logic              resp_err,
  output logic              mem_en,
  output logic [N_BITS-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [LAT-1:0]    vld_q, vld_d;
  logic [N_BITS-1:0] pc_q [LAT];
  logic [N_BITS-1:0] pc_d [LAT];
`ifdef IMEM_MISALIGN_CHK_EN
  logic [LAT-1:0]    err_q, err_d;
`endif
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic              accept, req_err;
  imem_resp_t        push_data, head;

  assign req_ready = rst_n && !flush && (out_q < CW'(DEPTH));
  assign accept    = req_valid && req_ready;
`ifdef IMEM_MISALIGN_CHK_EN
  assign req_err   = (req_addr[1:0] != 2'b00);
`else
  assign req_err   = 1'b0;
`endif
  assign mem_en    = accept && !req_err;
  assign mem_addr  = mem_en ? {req_addr[N_BITS-1:2], 2'b00} : '0;

  // In-flight pipeline: stage LAT-1 lines up with mem_rdata.
  always_comb begin
    vld_d = vld_q;
    pc_d  = pc_q;
`ifdef IMEM_MISALIGN_CHK_EN
    err_d = err_q;
`endif
    if (flush) begin
      vld_d = '0;
    end else begin
      vld_d[0] = accept;
      pc_d[0]  = req_addr;
`ifdef IMEM_MISALIGN_CHK_EN
      err_d[0] = req_err;
`endif
      for (int i = 1; i < LAT; i++) begin
        vld_d[i] = vld_q[i-1];
        pc_d[i]  = pc_q[i-1];
`ifdef IMEM_MISALIGN_CHK_EN
        err_d[i] = err_q[i-1];
`endif
      end
    end
  end

  // FIFO write record built from the landing stage.
  always_comb begin
    push_data       = '0;
    push_data.pc    = pc_q[LAT-1];
`ifdef IMEM_MISALIGN_CHK_EN
    push_data.err   = err_q[LAT-1];
    push_data.instr = err_q[LAT-1] ? 32'h0 : mem_rdata;
`else
    push_data.instr = mem_rdata;
`endif
  end

  assign fifo_push = vld_q[LAT-1] && !flush;
  assign fifo_pop  = resp_ready && !fifo_empty && !flush;

  // Outstanding credit count: in-flight plus buffered.
  always_comb begin
    out_d = out_q;
    if (flush) begin
      out_d = '0;
    end else begin
      case ({accept, fifo_pop})
        2'b10:   out_d = out_q + CW'(1);
        2'b01:   out_d = out_q - CW'(1);
        default: out_d = out_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) pc_q[i] <= '0;
`ifdef IMEM_MISALIGN_CHK_EN
      err_q <= '0;
`endif
      out_q <= '0;
    end else begin
      vld_q <= vld_d;
      pc_q  <= pc_d;
`ifdef IMEM_MISALIGN_CHK_EN
      err_q <= err_d;
`endif
      out_q <= out_d;
    end
  end

  dl_fifo_sync #(
    .WIDTH ($bits(imem_resp_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (fifo_push),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign resp_valid = !fifo_empty;
  assign resp_pc    = head.pc;
  assign resp_instr = head.instr;
`ifdef IMEM_MISALIGN_CHK_EN
  assign resp_err   = head.err;
`else
  assign resp_err   = 1'b0;
`endif

  imem_resp_unit_chk #(.DEPTH(DEPTH)) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .outstanding (out_q),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full)
  );

endmodule
